// File: rtl/bidir_turnaround_ctrl_pkg.sv
// rtl/bidir_turnaround_ctrl_pkg.sv - shared types and constants for the bidir turnaround controller
// FSM state encoding and line-side identifiers.
package bidir_turnaround_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRV_A,
        DRV_B,
        TURN
    } state_t;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

endpackage

// File: rtl/bidir_turnaround_ctrl_if.sv
// rtl/bidir_turnaround_ctrl_if.sv - request/grant bundle between the two line drivers and the controller
// master: the requesting sides; slave: the direction controller.
interface bidir_turnaround_ctrl_if;

    logic req_a;
    logic req_b;
    logic last_a;
    logic last_b;
    logic gnt_a;
    logic gnt_b;
    logic oe_a;
    logic oe_b;
    logic dir;
    logic busy;

    modport master (
        output req_a, req_b, last_a, last_b,
        input  gnt_a, gnt_b, oe_a, oe_b, dir, busy
    );

    modport slave (
        input  req_a, req_b, last_a, last_b,
        output gnt_a, gnt_b, oe_a, oe_b, dir, busy
    );

endinterface

// File: rtl/bidir_turnaround_ctrl_down_counter.sv
// rtl/bidir_turnaround_ctrl_down_counter.sv - loadable down-counter with zero flag (ta_down_counter)
// Decrement stops at zero so the flag stays asserted until the next load.
module ta_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/bidir_turnaround_ctrl.sv
// rtl/bidir_turnaround_ctrl.sv - one-owner direction controller for a shared bidirectional line
// Optional turnaround statistics counter: BIDIR_TURNAROUND_STATS_EN.
module bidir_turnaround_ctrl
    import bidir_turnaround_ctrl_pkg::*;
#(
    parameter int TURN_CYCLES = 2,
    parameter int MAX_BURST   = 16
`ifdef BIDIR_TURNAROUND_STATS_EN
    , parameter int CNT_W     = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    bidir_turnaround_ctrl_if.slave    bus
`ifdef BIDIR_TURNAROUND_STATS_EN
    , output logic [CNT_W-1:0]        turn_cnt
`endif
);

    localparam int TW = $clog2(TURN_CYCLES + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t r_state;
    state_t w_state_next;
    logic   r_dir;
    logic   w_dir_next;
    logic   r_last_owner;
    logic   w_owner_next;
    logic   w_winner;
    logic   w_beat;
    logic   w_turn_zero;
    logic   w_beat_zero;
    logic   w_end_a;
    logic   w_end_b;

    // Tie goes to the side that did not own the previous burst.
    assign w_winner = (bus.req_a && bus.req_b) ? ~r_last_owner : bus.req_b;
    assign w_beat   = ((r_state == DRV_A) && bus.req_a) || ((r_state == DRV_B) && bus.req_b);
    assign w_end_a  = !bus.req_a || bus.last_a || (w_beat_zero && bus.req_b);
    assign w_end_b  = !bus.req_b || bus.last_b || (w_beat_zero && bus.req_a);

    // Gap counter holds TURN_CYCLES-1 outside TURN; zero marks the final released cycle.
    ta_down_counter #(.W(TW)) u_turn_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state != TURN),
        .i_load_val (TW'(TURN_CYCLES - 1)),
        .i_dec      (r_state == TURN),
        .o_zero     (w_turn_zero)
    );

    // Zero during a beat means this beat is number MAX_BURST or later.
    ta_down_counter #(.W(BW)) u_beat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     ((r_state == IDLE) || (r_state == TURN)),
        .i_load_val (BW'(MAX_BURST - 1)),
        .i_dec      (w_beat),
        .o_zero     (w_beat_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_owner_next = r_last_owner;
        case (r_state)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    if (w_winner == r_dir) begin
                        w_state_next = w_winner ? DRV_B : DRV_A;
                    end else begin
                        w_state_next = TURN;
                        w_dir_next   = w_winner;
                    end
                end
            end
            DRV_A: begin
                if (w_end_a) begin
                    w_owner_next = SIDE_A;
                    if (bus.req_b) begin
                        w_state_next = TURN;
                        w_dir_next   = SIDE_B;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            DRV_B: begin
                if (w_end_b) begin
                    w_owner_next = SIDE_B;
                    if (bus.req_a) begin
                        w_state_next = TURN;
                        w_dir_next   = SIDE_A;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            TURN: begin
                if (w_turn_zero) begin
                    w_state_next = r_dir ? DRV_B : DRV_A;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_dir        <= SIDE_A;
            r_last_owner <= SIDE_B;
        end else begin
            r_state      <= w_state_next;
            r_dir        <= w_dir_next;
            r_last_owner <= w_owner_next;
        end
    end

    assign bus.gnt_a = (r_state == DRV_A);
    assign bus.gnt_b = (r_state == DRV_B);
    assign bus.oe_a  = (r_state == DRV_A);
    assign bus.oe_b  = (r_state == DRV_B);
    assign bus.dir   = r_dir;
    assign bus.busy  = (r_state != IDLE);

`ifdef BIDIR_TURNAROUND_STATS_EN
    logic [CNT_W-1:0] r_turn_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_turn_cnt <= '0;
        end else if ((r_state == TURN) && w_turn_zero) begin
            r_turn_cnt <= r_turn_cnt + CNT_W'(1);
        end
    end

    assign turn_cnt = r_turn_cnt;
`endif

endmodule

// File: tb/tb_bidir_turnaround_ctrl.sv
// tb/tb_bidir_turnaround_ctrl.sv - vector table, corner sequences and random run for bidir_turnaround_ctrl
// Runs with TURN_CYCLES=2, MAX_BURST=4; turn_cnt checks under BIDIR_TURNAROUND_STATS_EN.
module tb_bidir_turnaround_ctrl;

    typedef struct packed {
        logic [4:0] in;   // {rst, req_a, req_b, last_a, last_b}
        logic [3:0] exp;  // {gnt_a, gnt_b, dir, busy} in the following cycle
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    logic [5:0] exp_q[$];

    bidir_turnaround_ctrl_if bif ();
`ifdef BIDIR_TURNAROUND_STATS_EN
    logic [15:0] turn_cnt;
`endif

    bidir_turnaround_ctrl #(
        .TURN_CYCLES (2),
        .MAX_BURST   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif)
`ifdef BIDIR_TURNAROUND_STATS_EN
        , .turn_cnt (turn_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        if ((bif.oe_a & bif.oe_b) === 1'b1) begin
            errors++;
            $display("FAIL oe_exclusive: oe_a=%b oe_b=%b required not both 1 at %0t", bif.oe_a, bif.oe_b, $time);
        end
    end

    task automatic add(input logic [4:0] in, input logic [3:0] exp, input int n = 1);
        for (int k = 0; k < n; k++) vecs.push_back('{in: in, exp: exp});
    endtask

    int   dir_changes;
    int   idle_run;
    logic prev_side;

    task automatic track();
        if (bif.gnt_a || bif.gnt_b) begin
            if (bif.gnt_b != prev_side) begin
                dir_changes++;
                checks++;
                if (idle_run < 2) begin
                    errors++;
                    $display("FAIL turn_gap: released cycles %0d required >= 2 at %0t", idle_run, $time);
                end
            end
            prev_side = bif.gnt_b;
            idle_run  = 0;
        end else begin
            idle_run++;
        end
    endtask

    initial begin
        logic [5:0] got;
        logic [5:0] e;
        bif.req_a = 1'b0; bif.req_b = 1'b0; bif.last_a = 1'b0; bif.last_b = 1'b0;

        // rst_ra_rb_la_lb -> ga_gb_dir_busy
        add(5'b10000, 4'b0000);
        add(5'b01000, 4'b1001, 3);      // A from reset: same direction, 1-cycle grant
        add(5'b01010, 4'b0000);         // last on 3rd beat
        add(5'b00000, 4'b0000);
        add(5'b00100, 4'b0011, 2);      // B only: two released cycles
        add(5'b00100, 4'b0111);
        add(5'b00101, 4'b0010);
        add(5'b01100, 4'b0001, 2);      // tie, last owner B: A wins via TURN
        add(5'b01100, 4'b1001, 4);
        add(5'b01100, 4'b0011, 2);      // 4th beat with B waiting: preempt
        add(5'b01100, 4'b0111);
        add(5'b01101, 4'b0001);         // last_b with req_a: straight into TURN
        add(5'b01000, 4'b0001);
        add(5'b01000, 4'b1001, 7);      // uncapped stream beyond MAX_BURST
        add(5'b01100, 4'b0011);         // late request preempts saturated burst
        add(5'b00100, 4'b0011);
        add(5'b00100, 4'b0111);
        add(5'b00000, 4'b0010);         // dropped req ends burst, dir kept
        add(5'b01000, 4'b0001, 2);
        add(5'b11000, 4'b0000);         // reset in 2nd TURN cycle
        add(5'b01000, 4'b1001);
        add(5'b01010, 4'b0000);
        add(5'b10000, 4'b0000);
        add(5'b01100, 4'b1001);         // tie from reset: A wins directly
        add(5'b01110, 4'b0011);
        add(5'b00100, 4'b0011);
        add(5'b00100, 4'b0111);
        add(5'b00101, 4'b0010);
        add(5'b01100, 4'b0001);         // next tie goes to A
        add(5'b00000, 4'b0001);
        add(5'b00000, 4'b1001);         // TURN exits unconditionally
        add(5'b00000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            {rst, bif.req_a, bif.req_b, bif.last_a, bif.last_b} = vecs[i].in;
            exp_q.push_back({vecs[i].exp[3], vecs[i].exp[2], vecs[i].exp[3], vecs[i].exp[2],
                             vecs[i].exp[1], vecs[i].exp[0]});
            @(posedge clk);
            #1;
            got = {bif.gnt_a, bif.gnt_b, bif.oe_a, bif.oe_b, bif.dir, bif.busy};
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL row_%0d gnt_a,gnt_b,oe_a,oe_b,dir,busy: got %b required %b", i, got, e);
            end
`ifdef BIDIR_TURNAROUND_STATS_EN
            if (vecs[i].in[4]) begin
                checks++;
                if (turn_cnt !== 16'd0) begin
                    errors++;
                    $display("FAIL turn_cnt_reset row_%0d: got %0d required 0", i, turn_cnt);
                end
            end
`endif
        end

        @(negedge clk);
        rst = 1'b1;
        bif.req_a = 1'b0; bif.req_b = 1'b0; bif.last_a = 1'b0; bif.last_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dir_changes = 0;
        idle_run    = 0;
        prev_side   = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            track();
            if (!bif.req_a)     bif.req_a = ($urandom_range(0, 2) == 0);
            else if (bif.gnt_a) bif.req_a = ($urandom_range(0, 7) != 0);
            if (!bif.req_b)     bif.req_b = ($urandom_range(0, 2) == 0);
            else if (bif.gnt_b) bif.req_b = ($urandom_range(0, 7) != 0);
            bif.last_a = bif.gnt_a && ($urandom_range(0, 3) == 0);
            bif.last_b = bif.gnt_b && ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        track();

        checks++;
        if (dir_changes < 10) begin
            errors++;
            $display("FAIL random_dir_changes: got %0d required >= 10", dir_changes);
        end
`ifdef BIDIR_TURNAROUND_STATS_EN
        checks++;
        if (turn_cnt !== 16'(dir_changes)) begin
            errors++;
            $display("FAIL turn_cnt_random: got %0d required %0d", turn_cnt, dir_changes);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bidir_turnaround_ctrl.md
# bidir_turnaround_ctrl

Synthesizable direction controller for a shared bidirectional board line, such as memory DQ/DQS between the controller side (A) and the device side (B). Arbitrates between the two drivers and guarantees that only one side's output enable is ever asserted. Inserts a configurable all-released turnaround gap on every direction change and bounds burst length for fairness. Sits between the memory controller's read/write sequencer and the pad/line-delay model in the bench.

## Interface
- TURN_CYCLES, 2: released cycles on a direction change; must be ≥1
- MAX_BURST, 16: beats before the owner is preempted when the other side requests; must be ≥1
- CNT_W, 16: width of the statistics counter
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_a  in  1  side A wants to drive; held until granted
- req_b  in  1  side B wants to drive
- last_a  in  1  final beat of A's burst; sampled only with gnt_a
- last_b  in  1  final beat of B's burst; sampled only with gnt_b
- gnt_a  out  1  A owns the line this cycle
- gnt_b  out  1  B owns the line this cycle
- oe_a  out  1  A output enable; equals gnt_a
- oe_b  out  1  B output enable; equals gnt_b
- dir  out  1  last/current driving side: 0 = A, 1 = B
- busy  out  1  not in IDLE
- turn_cnt  out  CNT_W  number of completed turnarounds; present only with the macro

## Operation
- States:
  - IDLE
  - DRV_A
  - DRV_B
  - TURN
- Beat: a cycle with gnt_x & req_x. Beat counter resets on entry to DRV_x.
- IDLE arbitration:
  - Only one side requests: that side wins.
  - Both request: the side that did not own the previous burst wins (round-robin pointer `last_owner`).
  - If the winner equals dir, go to DRV_winner.
  - Otherwise go to TURN and set dir to the winner.
- DRV_x burst end is any of:
  - last_x during a beat
  - req_x low
  - beat count reaching MAX_BURST while the other side requests
- On burst end, update last_owner ← x. Then:
  - Other side requesting → TURN, dir flips.
  - Otherwise → IDLE, dir retained.
- TURN:
  - gnt_a, gnt_b, oe_a and oe_b all low for exactly TURN_CYCLES cycles.
  - Then DRV_dir unconditionally; a dropped request simply ends that burst after one granted cycle.
- Invariant: oe_a & oe_b is never 1. The bench asserts this every cycle.
- A burst that reaches MAX_BURST with no competing request continues uncapped. The counter saturates at MAX_BURST.
- Simultaneous last_a and a new req_b in the same cycle: burst ends and TURN starts. No extra IDLE cycle.
- Outputs are registered and decoded from state only. No combinational path from inputs to gnt/oe.

## Timing
- Reset (rst high at an edge): next cycle state is IDLE with:
  - gnt_a, gnt_b, oe_a, oe_b, busy = 0
  - dir = 0
  - last_owner = B, so A wins the first tie
  - turn_cnt = 0
- Reset mid-burst or mid-TURN applies the same values at the next edge. No burst completion is reported.
- Same-direction grant: req at cycle n in IDLE → gnt at n+1.
- Direction-change grant: req at n → TURN for n+1..n+TURN_CYCLES → gnt at n+1+TURN_CYCLES.
- Burst end at cycle m (last or preempt) → gnt low at m+1.
  - If the other side is requesting, its gnt rises at m+1+TURN_CYCLES.
- Dropping req_x while granted: the cycle with req_x low is not a beat; gnt_x falls the following cycle.

## Configuration
- BIDIR_TURNAROUND_STATS_EN:
  - Defined: turn_cnt port exists and increments by 1 on each TURN→DRV transition. Wraps modulo 2^CNT_W.
  - Undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - state enum (IDLE, DRV_A, DRV_B, TURN)
  - side constants SIDE_A = 0, SIDE_B = 1
- Sub-module `ta_down_counter`: loadable down-counter with a zero flag, instanced twice:
  - turnaround gap, width $clog2(TURN_CYCLES+1)
  - beat limit, width $clog2(MAX_BURST+1)
- The FSM, arbitration pointer and output registers stay in the top module.

## Test plan
All scenarios use TURN_CYCLES=2 and MAX_BURST=4.
- Post-reset, req_a at cycle 0, last_a on the 3rd beat → gnt_a cycles 1–3, no TURN, dir stays 0.
- A burst then req_b only (req at cycle 10) → TURN at cycles 11–12, gnt_b at 13, dir=1; both oe low at 11–12.
- req_a and req_b rise together from reset → A wins. After A's last, B follows after 2 released cycles. Next tie goes to A.
- A holds req_a with no last while req_b is asserted → exactly 4 A beats, 2 TURN cycles, then gnt_b. Without req_b, A streams more than 4 beats.
- rst pulsed in the 2nd TURN cycle → next cycle all outputs 0, dir=0, and with stats enabled turn_cnt=0. Later req_a is granted in 1 cycle.
- Randomized req/last for 10k cycles → oe_a & oe_b never both 1. Every direction change has ≥2 released cycles, and turn_cnt equals the number of direction changes.
